// File: rtl/ball_plotter_if.sv
// ball_plotter_if: position-in / pixel-out bundle between ball_pos, ball_plotter and draw
interface ball_plotter_if;
  logic       start;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       writeEn;
  modport master (output start, new_x, new_y, input busy, done, x, y, color, writeEn);
  modport slave (input start, new_x, new_y, output busy, done, x, y, color, writeEn);
endinterface

// File: rtl/ball_plotter.sv
// ball_plotter: erases the old ball square then draws the new one, one pixel per clock (option BALL_PLOT_SKIP_SAME_EN)
module ball_plotter #(
  parameter int         BALL_SIZE  = 2,
  parameter logic [2:0] BALL_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR   = 3'b000,
  parameter int         X_MAX      = 160,
  parameter int         Y_MAX      = 120
) (
  input logic           clk,
  input logic           reset,
  ball_plotter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  localparam logic [2:0] LAST = 3'(BALL_SIZE - 1);
  state_t     state, nstate;
  logic [2:0] dx, dy, ndx, ndy;
  logic [7:0] cur_x, old_x, ncur_x, bx;
  logic [6:0] cur_y, old_y, ncur_y, by;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       old_valid, wrap, last, same, pix;
  // Next state, next raster position and the pixel address it implies; sums are one bit wider so off-screen wraps are caught
  always_comb begin
    wrap = dx == LAST;
    last = wrap && dy == LAST;
`ifdef BALL_PLOT_SKIP_SAME_EN
    same = old_valid && bus.new_x == old_x && bus.new_y == old_y;
`else
    same = 1'b0;
`endif
    nstate = state;
    ndx = dx;
    ndy = dy;
    ncur_x = cur_x;
    ncur_y = cur_y;
    case (state)
      IDLE: if (bus.start) begin
        ncur_x = bus.new_x;
        ncur_y = bus.new_y;
        ndx = 3'd0;
        ndy = 3'd0;
        nstate = same ? DONE : old_valid ? ERASE : DRAW;
      end
      ERASE: begin
        ndx = last ? 3'd0 : wrap ? 3'd0 : dx + 3'd1;
        ndy = last ? 3'd0 : wrap ? dy + 3'd1 : dy;
        nstate = last ? DRAW : ERASE;
      end
      DRAW: begin
        ndx = wrap ? 3'd0 : dx + 3'd1;
        ndy = wrap ? dy + 3'd1 : dy;
        nstate = last ? DONE : DRAW;
      end
      default: nstate = IDLE;
    endcase
    bx = nstate == ERASE ? old_x : ncur_x;
    by = nstate == ERASE ? old_y : ncur_y;
    sx = {1'b0, bx} + {6'd0, ndx};
    sy = {1'b0, by} + {5'd0, ndy};
    pix = nstate == ERASE || nstate == DRAW;
  end
  // FSM state, position memory and registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dx <= 3'd0;
      dy <= 3'd0;
      cur_x <= 8'd0;
      cur_y <= 7'd0;
      old_x <= 8'd0;
      old_y <= 7'd0;
      old_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.writeEn <= 1'b0;
      bus.x <= 8'd0;
      bus.y <= 7'd0;
      bus.color <= BG_COLOR;
    end else begin
      state <= nstate;
      dx <= ndx;
      dy <= ndy;
      cur_x <= ncur_x;
      cur_y <= ncur_y;
      if (state == DONE) begin
        old_x <= cur_x;
        old_y <= cur_y;
        old_valid <= 1'b1;
      end
      bus.busy <= nstate != IDLE;
      bus.done <= nstate == DONE;
      bus.writeEn <= pix && sx < 9'(X_MAX) && sy < 8'(Y_MAX);
      if (pix) begin
        bus.x <= sx[7:0];
        bus.y <= sy[6:0];
        bus.color <= nstate == DRAW ? BALL_COLOR : BG_COLOR;
      end
    end
  end
endmodule
